// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg : shared types and constants for the multicycle MIPS controller
// Optional feature macro: MC_BNE_EN (adds the bne execute state)
// Revision: 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
`ifdef MC_BNE_EN
      S_BNEEX   = 4'd13,
`endif
      S_TRAP    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that stall on the memory handshake and feed the timeout counter.
   function automatic logic is_mem_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_aludec.sv
// ============================================================================
// mc_aludec : R-type funct field to ALU control decoder with validity flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_aludec
   import mc_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [2:0] alucontrol_o,
   output logic       valid_o
);

   always_comb begin
      alucontrol_o = 3'b000;
      valid_o      = 1'b1;
      case (funct_i)
         FN_ADD:  alucontrol_o = ALU_ADD;
         FN_SUB:  alucontrol_o = ALU_SUB;
         FN_AND:  alucontrol_o = ALU_AND;
         FN_OR:   alucontrol_o = ALU_OR;
         FN_SLT:  alucontrol_o = ALU_SLT;
         default: valid_o      = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// mc_controller : multicycle MIPS control FSM with memory handshake and trap
// Optional feature macro: MC_BNE_EN (bne dispatch to BNEEX)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TIMEOUT_W   = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcen,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       trap
);

   import mc_pkg::*;

   // Trap fires on the wait cycle that would make the MEM_TIMEOUT-th stall.
   localparam logic [TIMEOUT_W-1:0] c_wait_last =
      (MEM_TIMEOUT == 0) ? '0 : TIMEOUT_W'(MEM_TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic [TIMEOUT_W-1:0]   wait_q, wait_d;
   logic [2:0]             w_rtype_alu;
   logic                   w_rtype_ok;
   logic                   w_timeout;

   mc_aludec u_aludec (
      .funct_i      (funct),
      .alucontrol_o (w_rtype_alu),
      .valid_o      (w_rtype_ok)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      w_timeout = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == c_wait_last);
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_REG;
      pcsrc      = PCSRC_ALU;
      alucontrol = 3'b000;
      trap       = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alusrcb    = SRCB_FOUR;
            alucontrol = ALU_ADD;
            if (mem_ready) begin
               irwrite = 1'b1;
               pcen    = 1'b1;
               state_d = S_DECODE;
            end else if (w_timeout) begin
               state_d = S_TRAP;
            end
         end
         S_DECODE: begin
            alusrcb    = SRCB_IMMSH;
            alucontrol = ALU_ADD;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
               OP_BNE:       state_d = S_BNEEX;
`endif
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_IMM;
            alucontrol = ALU_ADD;
            state_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready)      state_d = S_MEMWB;
            else if (w_timeout) state_d = S_TRAP;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = mem_ready;
            if (mem_ready)      state_d = S_FETCH;
            else if (w_timeout) state_d = S_TRAP;
         end
         S_RTYPEEX: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_REG;
            alucontrol = w_rtype_alu;
            state_d    = w_rtype_ok ? S_RTYPEWB : S_TRAP;
         end
         S_RTYPEWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BEQEX: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = PCSRC_ALUOUT;
            pcen       = zero;
            state_d    = S_FETCH;
         end
`ifdef MC_BNE_EN
         S_BNEEX: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = PCSRC_ALUOUT;
            pcen       = ~zero;
            state_d    = S_FETCH;
         end
`endif
         S_ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = SRCB_IMM;
            alucontrol = ALU_ADD;
            state_d    = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcen    = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_d = S_TRAP;
         end
      endcase

      // Held in reset: nothing may be enabled or requested, even combinationally.
      if (!reset_n) begin
         mem_req    = 1'b0;
         memwrite   = 1'b0;
         irwrite    = 1'b0;
         pcen       = 1'b0;
         regwrite   = 1'b0;
         iord       = 1'b0;
         memtoreg   = 1'b0;
         regdst     = 1'b0;
         alusrca    = 1'b0;
         alusrcb    = SRCB_REG;
         pcsrc      = PCSRC_ALU;
         alucontrol = 3'b000;
         trap       = 1'b0;
      end
   end

   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (is_mem_wait_state(state_q) && !mem_ready && (wait_q != '1)) begin
         wait_d = wait_q + TIMEOUT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// tb_mc_controller : directed bench with route-table reference model for mc_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mc_controller;

   localparam int TO = 16;

   // Instruction-step codes used by the reference model.
   localparam int F  = 0,  D  = 1,  MA = 2,  MR = 3,  MB = 4,  MW = 5,  RX = 6;
   localparam int RW = 7,  BQ = 8,  AX = 9,  AW = 10, JX = 11, TR = 12, BN = 13;
   localparam int ND = 15;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, memwrite, irwrite, pcen, regwrite, iord, memtoreg, regdst, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic       trap;

   mc_controller #(.MEM_TIMEOUT(TO), .TIMEOUT_W(5)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
      .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite), .iord(iord),
      .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .trap(trap)
   );

   always #5 clk = ~clk;

   logic [16:0] dut_o;
   assign dut_o = {trap, mem_req, memwrite, irwrite, pcen, regwrite, iord,
                   memtoreg, regdst, alusrca, alusrcb, pcsrc, alucontrol};

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [3:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100000: return 4'b1_010;
         6'b100010: return 4'b1_110;
         6'b100100: return 4'b1_000;
         6'b100101: return 4'b1_001;
         6'b101010: return 4'b1_111;
         default:   return 4'b0_000;
      endcase
   endfunction

   // k-th step an instruction takes after its fetch; ND when finished.
   function automatic int route_step(input logic [5:0] o, input logic [5:0] f, input int k);
      int r [4];
      logic [3:0] a;
      a = alu_of(f);
      r = '{D, TR, ND, ND};
      case (o)
         6'b100011: r = '{D, MA, MR, MB};
         6'b101011: r = '{D, MA, MW, ND};
         6'b000000: r = '{D, RX, (a[3] ? RW : TR), ND};
         6'b000100: r = '{D, BQ, ND, ND};
         6'b001000: r = '{D, AX, AW, ND};
         6'b000010: r = '{D, JX, ND, ND};
`ifdef MC_BNE_EN
         6'b000101: r = '{D, BN, ND, ND};
`endif
         default:   r = '{D, TR, ND, ND};
      endcase
      if (k >= 4 || k < 0) return ND;
      return r[k];
   endfunction

   function automatic int cur_step(input logic t, input int p, input logic [5:0] o, input logic [5:0] f);
      if (t) return TR;
      if (p == 0) return F;
      return route_step(o, f, p - 1);
   endfunction

   function automatic logic [16:0] exp_out(input int s, input logic rdy, input logic z, input logic [5:0] f);
      logic [16:0] e;
      logic [3:0]  a;
      e = '0;
      a = alu_of(f);
      case (s)
         F:  begin e[15] = 1'b1; e[6:5] = 2'b01; e[2:0] = 3'b010; e[13] = rdy; e[12] = rdy; end
         D:  begin e[6:5] = 2'b11; e[2:0] = 3'b010; end
         MA: begin e[7] = 1'b1; e[6:5] = 2'b10; e[2:0] = 3'b010; end
         MR: begin e[15] = 1'b1; e[10] = 1'b1; end
         MB: begin e[11] = 1'b1; e[9] = 1'b1; end
         MW: begin e[15] = 1'b1; e[10] = 1'b1; e[14] = rdy; end
         RX: begin e[7] = 1'b1; e[2:0] = a[2:0]; end
         RW: begin e[11] = 1'b1; e[8] = 1'b1; end
         BQ: begin e[7] = 1'b1; e[2:0] = 3'b110; e[4:3] = 2'b01; e[12] = z; end
         BN: begin e[7] = 1'b1; e[2:0] = 3'b110; e[4:3] = 2'b01; e[12] = ~z; end
         AX: begin e[7] = 1'b1; e[6:5] = 2'b10; e[2:0] = 3'b010; end
         AW: begin e[11] = 1'b1; end
         JX: begin e[4:3] = 2'b10; e[12] = 1'b1; end
         TR: begin e[16] = 1'b1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   int          m_pos = 0;
   int          m_wait = 0;
   logic        m_trap = 1'b0;
   int          s_now;
   logic [16:0] exp_v;

   assign s_now = cur_step(m_trap, m_pos, op, funct);
   assign exp_v = reset_n ? exp_out(s_now, mem_ready, zero, funct) : 17'h0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pos  <= 0;
         m_wait <= 0;
         m_trap <= 1'b0;
      end else if (s_now == TR) begin
         m_trap <= 1'b1;
      end else if ((s_now == F || s_now == MR || s_now == MW) && !mem_ready) begin
         if (m_wait + 1 == TO) begin
            m_trap <= 1'b1;
            m_wait <= 0;
         end else begin
            m_wait <= m_wait + 1;
         end
      end else begin
         m_wait <= 0;
         m_pos  <= (route_step(op, funct, m_pos) == ND) ? 0 : m_pos + 1;
      end
   end

   int n_mw = 0, n_rw = 0, n_pc = 0;

   always @(negedge clk) begin
      chk("model_cycle", dut_o, exp_v);
      if (memwrite === 1'b1) n_mw++;
      if (regwrite === 1'b1) n_rw++;
      if (pcen === 1'b1)     n_pc++;
   end

   // ---------------- directed stimulus ----------------
   logic [16:0] probe_v;
   int          d_mw, d_rw, d_pc;

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Entered just after the edge that starts a FETCH cycle; runs n cycles,
   // stalling wlen extra cycles (mem_ready=0) before cycle index wat.
   task automatic instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input int n, input int wat, input int wlen,
                        input int probe);
      int mw0, rw0, pc0;
      op = o; funct = f; zero = z; mem_ready = 1'b1;
      #1;
      chk({nm, "_fetch"}, {12'd0, trap, mem_req, iord, alusrcb}, {12'd0, 5'b01001});
      mw0 = n_mw; rw0 = n_rw; pc0 = n_pc;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < ((i == wat) ? wlen : 0); k++) begin
            mem_ready = 1'b0;
            #1;
            adv();
         end
         mem_ready = 1'b1;
         #1;
         if (i == probe) probe_v = dut_o;
         adv();
      end
      d_mw = n_mw - mw0;
      d_rw = n_rw - rw0;
      d_pc = n_pc - pc0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      adv();
      adv();
      reset_n = 1'b1;
   endtask

   logic [5:0] fns  [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
   logic [2:0] alus [4] = '{3'b010, 3'b110, 3'b000, 3'b001};

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk("reset_outputs", dut_o, 17'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      instr("lw", 6'b100011, 6'd0, 1'b0, 5, -1, 0, 4);
      chk("lw_wb", {14'd0, probe_v[11], probe_v[9], probe_v[8]}, {14'd0, 3'b110});
      chk("lw_regwrite_cnt", 17'(d_rw), 17'd1);

      instr("sw", 6'b101011, 6'd0, 1'b0, 4, 3, 3, -1);
      chk("sw_memwrite_cnt", 17'(d_mw), 17'd1);

      instr("addi", 6'b001000, 6'd0, 1'b0, 4, -1, 0, 2);
      chk("addi_ex", {12'd0, probe_v[6:5], probe_v[2:0]}, {12'd0, 5'b10010});
      chk("addi_regwrite_cnt", 17'(d_rw), 17'd1);

      instr("beq1", 6'b000100, 6'd0, 1'b1, 3, -1, 0, 2);
      chk("beq_taken", {14'd0, probe_v[12], probe_v[4:3]}, {14'd0, 3'b101});
      chk("beq_taken_pcen_cnt", 17'(d_pc), 17'd2);
      instr("beq0", 6'b000100, 6'd0, 1'b0, 3, -1, 0, 2);
      chk("beq_not_taken", {14'd0, probe_v[12], probe_v[4:3]}, {14'd0, 3'b001});
      chk("beq_not_taken_pcen_cnt", 17'(d_pc), 17'd1);

      instr("j", 6'b000010, 6'd0, 1'b0, 3, -1, 0, 2);
      chk("j_ex", {14'd0, probe_v[12], probe_v[4:3]}, {14'd0, 3'b110});

      instr("slt", 6'b000000, 6'b101010, 1'b0, 4, -1, 0, 2);
      chk("slt_alu", {14'd0, probe_v[2:0]}, {14'd0, 3'b111});
      chk("slt_regwrite_cnt", 17'(d_rw), 17'd1);
      for (int i = 0; i < 4; i++) begin
         instr("rtype", 6'b000000, fns[i], 1'b0, 4, -1, 0, 2);
         chk("rtype_alu", {14'd0, probe_v[2:0]}, {14'd0, alus[i]});
      end

      instr("lw_wait", 6'b100011, 6'd0, 1'b0, 5, 3, 2, -1);
      chk("lw_wait_regwrite_cnt", 17'(d_rw), 17'd1);

      instr("fetch15", 6'b000010, 6'd0, 1'b0, 3, 0, 15, 1);
      chk("fetch15_decode", {14'd0, probe_v[16], probe_v[6:5]}, {14'd0, 3'b011});

`ifdef MC_BNE_EN
      instr("bne0", 6'b000101, 6'd0, 1'b0, 3, -1, 0, 2);
      chk("bne_taken", {14'd0, probe_v[12], probe_v[4:3]}, {14'd0, 3'b101});
      instr("bne1", 6'b000101, 6'd0, 1'b1, 3, -1, 0, 2);
      chk("bne_not_taken", {14'd0, probe_v[12], probe_v[4:3]}, {14'd0, 3'b001});
`else
      instr("bne_trap", 6'b000101, 6'd0, 1'b0, 2, -1, 0, -1);
      adv();
      chk("bne_trap", {16'd0, trap}, 17'd1);
      do_reset();
`endif

      // Reset mid-write: outputs must fall before the next clock edge.
      op = 6'b101011; mem_ready = 1'b1;
      adv();
      adv();
      mem_ready = 1'b0;
      adv();
      #1;
      chk("memwr_waiting", {14'd0, mem_req, memwrite, iord}, {14'd0, 3'b101});
      #1;
      reset_n = 1'b0;
      #1;
      chk("reset_async", dut_o, 17'h0);
      adv();
      adv();
      reset_n = 1'b1;

      instr("rbad", 6'b000000, 6'b000000, 1'b0, 3, -1, 0, -1);
      repeat (4) adv();
      chk("rbad_trap_sticky", {13'd0, trap, mem_req, pcen, regwrite}, {13'd0, 4'b1000});
      do_reset();

      instr("illegal", 6'b111111, 6'd0, 1'b0, 2, -1, 0, -1);
      adv();
      chk("illegal_trap", {16'd0, trap}, 17'd1);
      do_reset();

      op = 6'b000010; funct = 6'd0; mem_ready = 1'b0;
      #1;
      repeat (15) adv();
      chk("timeout_not_yet", {15'd0, trap, mem_req}, {15'd0, 2'b01});
      adv();
      chk("timeout_trap", {15'd0, trap, mem_req}, {15'd0, 2'b10});
      do_reset();

      instr("lw_after", 6'b100011, 6'd0, 1'b0, 5, -1, 0, -1);
      chk("lw_after_regwrite_cnt", 17'(d_rw), 17'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit. Sequences the shared datapath (one ALU, register file, unified instruction/data memory, PC/IR registers) through the fetch, decode and execute steps of each instruction.
- Drives all datapath mux selects, write enables and ALU control.
- Handshakes with a variable-latency memory through mem_req/mem_ready.
- Traps on illegal opcodes and on memory timeout.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles in a memory state with mem_ready=0 before entering TRAP; 0 disables the timeout.
- TIMEOUT_W, 5: width of the wait counter; must satisfy 2^TIMEOUT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- pcen  out  1  PC register enable
- regwrite  out  1  register file write enable
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memtoreg  out  1  writeback select: 0=ALUOut, 1=Data
- regdst  out  1  destination select: 0=rt, 1=rd
- alusrca  out  1  ALU A select: 0=PC, 1=A
- alusrcb  out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- pcsrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- trap  out  1  sticky fault indicator

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, TRAP. State is held in a register.
- Outputs are decoded combinationally from the state. Exception: irwrite, pcen, memwrite and the MEMRD->MEMWB advance are qualified by mem_ready.
- Reset (reset_n=0, asynchronous): state=FETCH, wait counter=0. All enables are 0 and trap=0. mem_req is 1 in FETCH as soon as reset releases.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - If mem_ready: irwrite=1, pcen=1, next state DECODE.
  - Else: hold, with all enables 0.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (computes the branch target). Dispatch on op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> RTYPEEX
  - 000100 (beq) -> BEQEX
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JEX
  - any other op -> TRAP
- MEMADR: alusrca=1, alusrcb=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Next state MEMWB on mem_ready; otherwise hold.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Next state FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=mem_ready. Next state FETCH on mem_ready; otherwise hold.
- RTYPEEX: alusrca=1, alusrcb=00. alucontrol decoded from funct:
  - 100000 add -> 010
  - 100010 sub -> 110
  - 100100 and -> 000
  - 100101 or -> 001
  - 101010 slt -> 111
  - any other funct -> TRAP instead of RTYPEWB
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Next state FETCH.
- BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next state ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next state FETCH.
- JEX: pcsrc=10, pcen=1. Next state FETCH.
- TRAP: absorbing state. trap=1, every enable 0, mem_req=0. Exit only by reset.
- Wait counter:
  - Increments each cycle spent in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Clears on any state change.
  - When MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, next state is TRAP.
  - If mem_ready arrives in that same cycle, mem_ready wins.
- Zero-wait latency: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each memory wait cycle adds 1.
- Unused selects read 0 in every state. Outputs never take X.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after the reset edge.

Optional Feature:
- Macro: MC_BNE_EN.
- Defined:
  - op 000101 (bne) dispatches from DECODE to BNEEX.
  - BNEEX matches BEQEX except pcen=~zero.
- Undefined:
  - op 000101 goes to TRAP.
  - The BNEEX state is not present in the RTL.

Decomposition:
- Shared package mc_pkg holds:
  - the state enumeration (4-bit encoding);
  - opcode and funct constants;
  - ALU control codes;
  - alusrcb and pcsrc select constants.
- One sub-module, mc_aludec: combinational funct-to-alucontrol decoder with a valid output; used in RTYPEEX.

Test Plan:
- Reset, then lw (op=100011), mem_ready held 1. Sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. regwrite=1, memtoreg=1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWR. memwrite stays 0 until mem_ready rises, then pulses exactly 1 cycle; back to FETCH.
- beq with zero=1 gives pcen=1 and pcsrc=01 in BEQEX; with zero=0, pcen=0. bne under MC_BNE_EN gives the inverse; without the macro, op 000101 reaches TRAP.
- R-type funct=101010 gives alucontrol=111 in RTYPEEX, then regwrite=1 and regdst=1. funct=000000 gives TRAP with trap=1 sticky.
- mem_ready=0 in FETCH for 16 cycles with MEM_TIMEOUT=16 enters TRAP. mem_ready=1 on the 16th cycle instead goes to DECODE.
- Assert reset_n=0 in MEMWR: outputs drop asynchronously before the next edge, memwrite=0, state=FETCH, trap=0.
